// File: rtl/slc3_mem_pkg.sv
// Shared types and widths for the SLC3 external SRAM path.
package slc3_mem_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_state_t;

    // Which requester owns the SRAM port
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick between CPU and loader. The pick is
// combinational; the last-grant history only advances when update_i is set.
module rr_arbiter2
    import slc3_mem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_cpu_i,
    input  logic req_ldr_i,
    input  logic update_i,
    output logic gnt_o,
    output logic valid_o
);

    grant_t last_grant_q;
    grant_t last_grant_d;
    grant_t pick_s;

    // Choose a winner: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        pick_s = GNT_CPU;
        if (req_cpu_i && req_ldr_i) begin
            pick_s = (last_grant_q == GNT_LDR) ? GNT_CPU : GNT_LDR;
        end else if (req_ldr_i) begin
            pick_s = GNT_LDR;
        end else begin
            pick_s = GNT_CPU;
        end
    end

    // Advance the history only when the pick is actually consumed
    always_comb begin
        last_grant_d = last_grant_q;
        if (update_i) begin
            last_grant_d = pick_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // History register; resets to loader so the CPU wins the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= GNT_LDR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt_o   = pick_s;
    assign valid_o = req_cpu_i | req_ldr_i;

endmodule

// File: rtl/sram_arbiter.sv
// Shares the external asynchronous SRAM between the SLC3 CPU memory stage
// and the program loader. Each access runs IDLE -> SETUP -> ACCESS -> DONE;
// all strobes, the address and the bus enable are registered and are
// computed from the next state so they line up with the state register.
module sram_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] Mem_bus,
    output logic              CE_out,
    output logic              OE_out,
    output logic              WE_out,
    output logic              UB_out,
    output logic              LB_out
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    sram_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    grant_t            gnt_q, gnt_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              bs_q, bs_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              bus_en_q, bus_en_d;
    logic              pick_s;
    logic              req_any_s;
    logic              grant_now_s;

    assign grant_now_s = (state_q == IDLE) && req_any_s;

    rr_arbiter2 u_rr (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .req_cpu_i (cpu_req),
        .req_ldr_i (ldr_req),
        .update_i  (grant_now_s),
        .gnt_o     (pick_s),
        .valid_o   (req_any_s)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and ACCESS down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_any_s) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Latch the winner's operands at grant; later operand changes are ignored
    always_comb begin
        gnt_d      = gnt_q;
        op_we_d    = op_we_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        if (grant_now_s) begin
            gnt_d = grant_t'(pick_s);
            if (grant_t'(pick_s) == GNT_CPU) begin
                op_we_d    = cpu_we;
                op_addr_d  = cpu_addr;
                op_wdata_d = cpu_wdata;
            end else begin
                op_we_d    = ldr_we;
                op_addr_d  = ldr_addr;
                op_wdata_d = ldr_wdata;
            end
        end else begin
            gnt_d = gnt_q;
        end
    end

    // Output logic: strobes, address and bus enable for the upcoming state
    always_comb begin
        ce_d     = 1'b1;
        oe_d     = 1'b1;
        we_d     = 1'b1;
        bs_d     = 1'b1;
        a_d      = a_q;
        bus_en_d = 1'b0;
        case (state_d)
            SETUP: begin
                ce_d = 1'b0;
                bs_d = 1'b0;
                a_d  = op_addr_d;
                oe_d = op_we_d;
            end
            ACCESS: begin
                ce_d = 1'b0;
                bs_d = 1'b0;
                a_d  = op_addr_d;
                if (op_we_d) begin
                    we_d     = 1'b0;
                    bus_en_d = 1'b1;
                end else begin
                    oe_d = 1'b0;
                end
            end
            default: begin
                ce_d     = 1'b1;
                bus_en_d = 1'b0;
            end
        endcase
    end

    // Read capture on the final ACCESS edge and one-cycle ack on entry to DONE
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        if ((state_q == ACCESS) && (cnt_q == 4'd0) && !op_we_q) begin
            if (gnt_q == GNT_CPU) begin
                cpu_rdata_d = Mem_bus;
            end else begin
                ldr_rdata_d = Mem_bus;
            end
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        cpu_ack_d = (state_d == DONE) && (gnt_q == GNT_CPU);
        ldr_ack_d = (state_d == DONE) && (gnt_q == GNT_LDR);
    end

    // Operand, output and read-data registers; reset parks the SRAM port idle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            gnt_q       <= GNT_CPU;
            op_we_q     <= 1'b0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            bs_q        <= 1'b1;
            a_q         <= '0;
            bus_en_q    <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            op_we_q     <= op_we_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            bs_q        <= bs_d;
            a_q         <= a_d;
            bus_en_q    <= bus_en_d;
        end
    end

    assign Mem_bus   = bus_en_q ? op_wdata_q : {DATA_W{1'bz}};
    assign A         = a_q;
    assign CE_out    = ce_q;
    assign OE_out    = oe_q;
    assign WE_out    = we_q;
    assign UB_out    = bs_q;
    assign LB_out    = bs_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural async SRAM, ack scoreboard and
// per-scenario tasks.
module tb_sram_arbiter;
    import slc3_mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [19:0] cpu_addr, ldr_addr, A;
    logic [15:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata;
    logic        cpu_ack, ldr_ack;
    logic        CE_out, OE_out, WE_out, UB_out, LB_out;
    wire  [15:0] Mem_bus;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .A(A), .Mem_bus(Mem_bus),
        .CE_out(CE_out), .OE_out(OE_out), .WE_out(WE_out), .UB_out(UB_out), .LB_out(LB_out)
    );

    always #10 Clk = ~Clk;

    // ---------------- asynchronous SRAM model (256 words) ----------------
    logic [15:0] mem [0:255];
    logic        sram_rd_s;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_pend = 1'b0;

    assign sram_rd_s = !CE_out && !OE_out && WE_out;
    assign Mem_bus   = sram_rd_s ? mem[A[7:0]] : {16{1'bz}};

    // Sample address/data while the write strobe is low
    always @(posedge Clk) begin
        if (CE_out === 1'b0 && WE_out === 1'b0) begin
            wr_addr = A[7:0];
            wr_data = Mem_bus;
            wr_pend = 1'b1;
        end
    end

    // Commit on the WE rising edge, unless that edge was caused by reset
    always @(posedge WE_out) begin
        if (Reset === 1'b1 && wr_pend) mem[wr_addr] = wr_data;
        wr_pend = 1'b0;
    end

    always @(negedge Reset) wr_pend = 1'b0;

    // A released bus reads as Z in a four-state simulator, zero in a two-state one
    function automatic bit bus_floating(input logic [15:0] v);
        return (v === {16{1'bz}}) || (v === 16'h0000);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_ldr;
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] exp_cpu_rd = 16'h0000;
    logic [15:0] exp_ldr_rd = 16'h0000;

    // Ack scoreboard plus bus-protocol monitor, sampled on the falling edge
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            checks++;
            if (OE_out === 1'b0 && WE_out === 1'b0) begin
                errors++; $display("FAIL oe_we_overlap OE=%b WE=%b required not both 0", OE_out, WE_out);
            end
            checks++;
            if (CE_out === 1'b0 && OE_out === 1'b0 && Mem_bus !== mem[A[7:0]]) begin
                errors++; $display("FAIL bus_contention bus=%h required %h", Mem_bus, mem[A[7:0]]);
            end
            checks++;
            if (OE_out !== 1'b0 && WE_out !== 1'b0 && !bus_floating(Mem_bus)) begin
                errors++; $display("FAIL bus_released bus=%h required Z", Mem_bus);
            end
            checks++;
            if (cpu_ack === 1'b1 && ldr_ack === 1'b1) begin
                errors++; $display("FAIL dual_ack cpu_ack=1 ldr_ack=1 required at most one");
            end
            if (cpu_ack === 1'b1 || ldr_ack === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_ack cpu_ack=%b ldr_ack=%b required none", cpu_ack, ldr_ack);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (ldr_ack !== mon_e.is_ldr) begin
                        errors++; $display("FAIL ack_owner ldr_ack=%b required %b", ldr_ack, mon_e.is_ldr);
                    end
                    if (mon_e.is_read) begin
                        if (mon_e.is_ldr) exp_ldr_rd = mon_e.data;
                        else              exp_cpu_rd = mon_e.data;
                    end
                end
                checks++;
                if (cpu_rdata !== exp_cpu_rd || ldr_rdata !== exp_ldr_rd) begin
                    errors++;
                    $display("FAIL rdata cpu=%h ldr=%h required cpu=%h ldr=%h",
                             cpu_rdata, ldr_rdata, exp_cpu_rd, exp_ldr_rd);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({CE_out, OE_out, WE_out, UB_out, LB_out} !== 5'b11111 || A !== 20'h0 ||
            cpu_ack !== 1'b0 || ldr_ack !== 1'b0 || cpu_rdata !== 16'h0 ||
            ldr_rdata !== 16'h0 || !bus_floating(Mem_bus)) begin
            errors++;
            $display("FAIL reset_state strobes=%b A=%h acks=%b%b rd=%h/%h bus=%h required 11111 0 00 0/0 Z",
                     {CE_out, OE_out, WE_out, UB_out, LB_out}, A, cpu_ack, ldr_ack,
                     cpu_rdata, ldr_rdata, Mem_bus);
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({CE_out, OE_out, WE_out, UB_out, LB_out} !== 5'b11111) begin
            errors++; $display("FAIL idle_after_reset strobes=%b required 11111",
                               {CE_out, OE_out, WE_out, UB_out, LB_out});
        end
    endtask

    task automatic test_ldr_write;
        int ack_cyc = 0;
        int we_low  = 0;
        ldr_we = 1'b1; ldr_addr = 20'h00005; ldr_wdata = 16'h005A; ldr_req = 1'b1;
        sb_q.push_back('{1'b1, 1'b0, 16'h0000});
        for (int cyc = 1; cyc <= 20 && ack_cyc == 0; cyc++) begin
            @(negedge Clk);
            if (WE_out === 1'b0) begin
                we_low++;
                checks++;
                if (A !== 20'h00005 || Mem_bus !== 16'h005A) begin
                    errors++; $display("FAIL ldr_wr_drive A=%h bus=%h required 00005 005a", A, Mem_bus);
                end
            end
            if (ldr_ack === 1'b1) ack_cyc = cyc;
        end
        ldr_req = 1'b0;
        checks++;
        if (ack_cyc != 4) begin
            errors++; $display("FAIL ldr_wr_latency got %0d required 4", ack_cyc);
        end
        checks++;
        if (we_low != 2) begin
            errors++; $display("FAIL ldr_wr_we_width got %0d required 2", we_low);
        end
        @(negedge Clk);
        checks++;
        if (mem[5] !== 16'h005A) begin
            errors++; $display("FAIL ldr_wr_mem got %h required 005a", mem[5]);
        end
    endtask

    task automatic test_cpu_read;
        int ack_cyc = 0;
        int oe_low  = 0;
        int we_low  = 0;
        cpu_we = 1'b0; cpu_addr = 20'h00005; cpu_wdata = 16'hFFFF; cpu_req = 1'b1;
        sb_q.push_back('{1'b0, 1'b1, 16'h005A});
        for (int cyc = 1; cyc <= 20 && ack_cyc == 0; cyc++) begin
            @(negedge Clk);
            if (OE_out === 1'b0) oe_low++;
            if (WE_out === 1'b0) we_low++;
            if (cpu_ack === 1'b1) ack_cyc = cyc;
        end
        cpu_req = 1'b0;
        checks++;
        if (ack_cyc != 4 || cpu_rdata !== 16'h005A) begin
            errors++; $display("FAIL cpu_rd_ack cyc=%0d data=%h required 4 005a", ack_cyc, cpu_rdata);
        end
        checks++;
        if (oe_low != 3 || we_low != 0) begin
            errors++; $display("FAIL cpu_rd_strobes oe_low=%0d we_low=%0d required 3 0", oe_low, we_low);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if (cpu_rdata !== 16'h005A) begin
            errors++; $display("FAIL cpu_rd_hold got %h required 005a", cpu_rdata);
        end
    endtask

    task automatic test_round_robin;
        int n = 0;
        int ack_at[3];
        logic who[3];
        Reset = 1'b0;
        @(negedge Clk);
        exp_cpu_rd = 16'h0000; exp_ldr_rd = 16'h0000;
        Reset = 1'b1;
        @(negedge Clk);
        cpu_we = 1'b0; cpu_addr = 20'h00008;
        ldr_we = 1'b0; ldr_addr = 20'h00009;
        sb_q.push_back('{1'b0, 1'b1, mem[8]});
        sb_q.push_back('{1'b1, 1'b1, mem[9]});
        sb_q.push_back('{1'b0, 1'b1, mem[8]});
        cpu_req = 1'b1; ldr_req = 1'b1;
        for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
            @(negedge Clk);
            if (cpu_ack === 1'b1 || ldr_ack === 1'b1) begin
                ack_at[n] = cyc; who[n] = ldr_ack; n++;
                if (n == 3) begin cpu_req = 1'b0; ldr_req = 1'b0; end
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL rr_count got %0d acks required 3", n);
        end else begin
            checks++;
            if (who[0] !== 1'b0 || who[1] !== 1'b1 || who[2] !== 1'b0) begin
                errors++; $display("FAIL rr_order got %b%b%b required 010 (0=cpu)", who[0], who[1], who[2]);
            end
            checks++;
            if (ack_at[1] - ack_at[0] != 5 || ack_at[2] - ack_at[1] != 5) begin
                errors++; $display("FAIL rr_spacing got %0d,%0d required 5,5",
                                   ack_at[1] - ack_at[0], ack_at[2] - ack_at[1]);
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_operand_change;
        int ack_cyc = 0;
        int a_bad   = 0;
        cpu_we = 1'b0; cpu_addr = 20'h00003; cpu_req = 1'b1;
        sb_q.push_back('{1'b0, 1'b1, mem[3]});
        for (int cyc = 1; cyc <= 20 && ack_cyc == 0; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) cpu_addr = 20'h00010;
            if (cyc == 2) cpu_req = 1'b0;
            if (CE_out === 1'b0 && A !== 20'h00003) a_bad++;
            if (cpu_ack === 1'b1) ack_cyc = cyc;
        end
        cpu_req = 1'b0;
        checks++;
        if (a_bad != 0 || ack_cyc != 4) begin
            errors++; $display("FAIL opchg a_bad=%0d ack_cyc=%0d required 0 4", a_bad, ack_cyc);
        end
        @(negedge Clk);
    endtask

    task automatic test_drop_before_grant;
        int act = 0;
        cpu_we = 1'b1; cpu_addr = 20'h00004; cpu_wdata = 16'h1234; cpu_req = 1'b1;
        #5 cpu_req = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge Clk);
            if (CE_out !== 1'b1 || cpu_ack !== 1'b0) act++;
        end
        checks++;
        if (act != 0 || mem[4] !== 16'hA004) begin
            errors++; $display("FAIL drop_pre_grant active=%0d mem4=%h required 0 a004", act, mem[4]);
        end
    endtask

    task automatic test_reset_mid_write;
        int seen = 0;
        int late = 0;
        ldr_we = 1'b1; ldr_addr = 20'h00007; ldr_wdata = 16'hBEEF; ldr_req = 1'b1;
        for (int cyc = 1; cyc <= 10 && seen == 0; cyc++) begin
            @(negedge Clk);
            if (WE_out === 1'b0) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL rst_mid_reach_access got no WE low required WE low within 10");
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({CE_out, OE_out, WE_out, UB_out, LB_out} !== 5'b11111 || ldr_ack !== 1'b0 ||
            !bus_floating(Mem_bus)) begin
            errors++; $display("FAIL rst_mid_async strobes=%b ldr_ack=%b bus=%h required 11111 0 Z",
                               {CE_out, OE_out, WE_out, UB_out, LB_out}, ldr_ack, Mem_bus);
        end
        ldr_req = 1'b0;
        sb_q.delete();
        exp_cpu_rd = 16'h0000; exp_ldr_rd = 16'h0000;
        @(negedge Clk);
        Reset = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge Clk);
            if (ldr_ack !== 1'b0 || WE_out !== 1'b1) late++;
        end
        checks++;
        if (late != 0 || mem[7] !== 16'hA007) begin
            errors++; $display("FAIL rst_mid_lost late=%0d mem7=%h required 0 a007", late, mem[7]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        Reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 20'h0; cpu_wdata = 16'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 20'h0; ldr_wdata = 16'h0;
        test_reset();
        test_ldr_write();
        test_cpu_read();
        test_round_robin();
        test_operand_change();
        test_drop_before_grant();
        test_reset_mid_write();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain pending=%0d required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
